// File: rtl/burst_main_memory_if.sv
// -----------------------------------------------------------------------------
// burst_main_memory_if
//   Request/response bundle between a block-transfer client (cache controller
//   or testbench) and burst_main_memory.
//
//   Request channel  (master -> slave unless noted):
//     req_valid   request present
//     req_ready   slave -> master, request accepted when valid && ready
//     req_write   1 = block write, 0 = block read
//     req_addr    word address, low bits select the requested word
//     req_wdata   whole write block, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Response channel (slave -> master unless noted):
//     resp_valid  beat present
//     resp_ready  master -> slave, beat consumed when valid && ready
//     resp_data   read word, zero on the write acknowledge
//     resp_last   final read beat or the write acknowledge
// -----------------------------------------------------------------------------
interface burst_main_memory_if #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int BLOCK_WORDS = 4
);
   logic                              req_valid;
   logic                              req_ready;
   logic                              req_write;
   logic [ADDR_WIDTH-1:0]             req_addr;
   logic [BLOCK_WORDS*DATA_WIDTH-1:0] req_wdata;
   logic                              resp_valid;
   logic                              resp_ready;
   logic [DATA_WIDTH-1:0]             resp_data;
   logic                              resp_last;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_last
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_data, resp_last
   );
endinterface

// File: rtl/burst_main_memory.sv
// -----------------------------------------------------------------------------
// burst_main_memory
//   Block-oriented main memory for the cache controller. A request is accepted
//   in IDLE, waits LATENCY cycles (DRAM delay model), then either streams
//   BLOCK_WORDS read beats or stores a whole block and returns one acknowledge.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset (memory contents are kept)
//     bus   burst_main_memory_if.slave request/response channels
//
//   Optional feature (macro BURST_MEM_CRITICAL_WORD_FIRST_EN):
//     defined   -> read bursts start at the requested word and wrap inside the
//                  block
//     undefined -> read bursts always start at word 0 of the block
//   Writes always store word 0 first in either build.
//
//   Storage is a single-ported array with a registered read port; every cycle
//   performs at most one read or one write.
// -----------------------------------------------------------------------------
module burst_main_memory #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int BLOCK_WORDS = 4,
   parameter int LATENCY     = 4
) (
   input  logic                clk,
   input  logic                rst,
   burst_main_memory_if.slave  bus
);
   localparam int OFF_W = $clog2(BLOCK_WORDS);
   localparam int IDX_W = OFF_W + 1;
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam int BASE_W = ADDR_WIDTH - OFF_W;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      RBURST = 3'd2,
      WRITE  = 3'd3,
      WACK   = 3'd4
   } state_t;

   state_t                            state_q, state_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [BASE_W-1:0]                 base_q, base_d;
   logic                              write_q, write_d;
   logic [BLOCK_WORDS*DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [OFF_W-1:0]                  beat_q, beat_d;
   // One extra bit so the index can reach BLOCK_WORDS: the cycle after the
   // last word is stored is spent before the acknowledge goes out.
   logic [IDX_W-1:0]                  widx_q, widx_d;

   logic                              accept;
   logic                              mem_re;
   logic                              mem_we;
   logic [OFF_W-1:0]                  rd_beat;
   logic [OFF_W-1:0]                  rd_word;
   logic [OFF_W-1:0]                  wr_word;
   logic [ADDR_WIDTH-1:0]             rd_addr;
   logic [ADDR_WIDTH-1:0]             wr_addr;
   logic [DATA_WIDTH-1:0]             rdata_q;

   logic                              req_ready;
   logic                              resp_valid;
   logic                              resp_last;
   logic [DATA_WIDTH-1:0]             resp_data;

   logic [DATA_WIDTH-1:0]             mem_array [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0]             wword [BLOCK_WORDS];

   // Split the latched write block into words for indexed selection.
   generate
      for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_wword
         assign wword[gi] = wdata_q[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

`ifdef BURST_MEM_CRITICAL_WORD_FIRST_EN
   logic [OFF_W-1:0] off_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         off_q <= '0;
      end else if (accept) begin
         off_q <= bus.req_addr[OFF_W-1:0];
      end
   end

   // Modulo-BLOCK_WORDS add: the carry out of OFF_W bits is dropped, so the
   // burst wraps inside the aligned block.
   assign rd_word = rd_beat + off_q;
`else
   assign rd_word = rd_beat;
`endif

   assign wr_word = widx_q[OFF_W-1:0];
   // Upper bits fixed to the block base: no carry into them, so the top block
   // never wraps to address 0.
   assign rd_addr = {base_q, rd_word};
   assign wr_addr = {base_q, wr_word};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      base_d     = base_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      beat_d     = beat_q;
      widx_d     = widx_q;
      accept     = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      rd_beat    = '0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_last  = 1'b0;
      resp_data  = '0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               accept  = 1'b1;
               base_d  = bus.req_addr[ADDR_WIDTH-1:OFF_W];
               write_d = bus.req_write;
               wdata_d = bus.req_wdata;
               cnt_d   = CNT_W'(LATENCY);
               state_d = WAIT;
            end
         end

         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               beat_d = '0;
               widx_d = '0;
               if (write_q) begin
                  state_d = WRITE;
               end else begin
                  // Prefetch beat 0 so it is registered when RBURST starts.
                  mem_re  = 1'b1;
                  rd_beat = '0;
                  state_d = RBURST;
               end
            end
         end

         RBURST: begin
            resp_valid = 1'b1;
            resp_data  = rdata_q;
            resp_last  = &beat_q;
            if (bus.resp_ready) begin
               if (&beat_q) begin
                  state_d = IDLE;
               end else begin
                  // Fetch the next beat on the handshake edge; while stalled
                  // rdata_q is not touched, so the beat holds.
                  beat_d  = beat_q + OFF_W'(1);
                  mem_re  = 1'b1;
                  rd_beat = beat_q + OFF_W'(1);
               end
            end
         end

         WRITE: begin
            if (!widx_q[OFF_W]) begin
               mem_we = 1'b1;
               widx_d = widx_q + IDX_W'(1);
            end else begin
               state_d = WACK;
            end
         end

         WACK: begin
            resp_valid = 1'b1;
            resp_last  = 1'b1;
            if (bus.resp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Reset wins: quiet outputs, no array access, nothing accepted.
      if (rst) begin
         accept     = 1'b0;
         mem_re     = 1'b0;
         mem_we     = 1'b0;
         req_ready  = 1'b0;
         resp_valid = 1'b0;
         resp_last  = 1'b0;
         resp_data  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         beat_q  <= '0;
         widx_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         beat_q  <= beat_d;
         widx_q  <= widx_d;
      end
   end

   // Storage: not reset, registered read.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_array[wr_addr] <= wword[wr_word];
      end
      if (mem_re) begin
         rdata_q <= mem_array[rd_addr];
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_last  = resp_last;
   assign bus.resp_data  = resp_data;
endmodule

// File: tb/tb_burst_main_memory.sv
// -----------------------------------------------------------------------------
// tb_burst_main_memory
//   Directed scenarios followed by randomized block reads/writes. Expected
//   response beats come from a word-level associative-array model of the
//   memory and are queued at request accept; a negedge monitor pops and
//   compares every response handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_burst_main_memory;
   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int BW  = 4;
   localparam int LAT = 4;

   typedef struct {
      logic [DW-1:0] data;
      bit            last;
      bit            dc;     // word content unknown, only resp_last checked
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   burst_main_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) bus ();

   burst_main_memory #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .BLOCK_WORDS(BW),
      .LATENCY    (LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int            checks = 0;
   int            passes = 0;
   exp_t          q[$];
   logic [DW-1:0] model [int];
   bit            busy = 1'b0;
   int            cyc = 0;
   int            acc_cyc = 0;
   int            rise_cyc = -1;
   int            last_hs_edge = -1;
   int            beats_done = 0;
   int            stall_cycles = 0;
   int            stall_left = 0;
   int            stall_beat = 1;
   bit            rand_ready = 1'b0;
   bit            prev_valid = 1'b0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   bit            prev_last = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [BW*DW-1:0] mk(input int w0, input int w1, input int w2, input int w3);
      logic [BW*DW-1:0] r;
      r = {DW'(w3), DW'(w2), DW'(w1), DW'(w0)};
      return r;
   endfunction

   function automatic logic [BW*DW-1:0] rnd_blk();
      logic [BW*DW-1:0] r;
      for (int i = 0; i < BW; i++) r[i*DW +: DW] = DW'($urandom);
      return r;
   endfunction

   // Issue one request (called aligned #1 after a rising edge). Holds
   // req_valid until accepted; on accept the model and scoreboard are updated.
   task automatic do_req(input bit wr, input int addr, input logic [BW*DW-1:0] wd, input bit track);
      int  t;
      bit  acc;
      int  base;
      t   = 0;
      acc = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = AW'(addr);
      bus.req_wdata = wd;
      while (!acc && t < 300) begin
         @(negedge clk);
         acc = bus.req_ready;
         t++;
         @(posedge clk);
         #1;
      end
      // Scramble the request fields: they must only matter at accept.
      bus.req_valid = 1'b0;
      bus.req_write = $urandom_range(0, 1);
      bus.req_addr  = AW'($urandom);
      bus.req_wdata = rnd_blk();
      chk(acc, "req_accept", acc, 1);
      if (acc) begin
         acc_cyc = cyc;
         busy    = 1'b1;
         base    = addr - (addr % BW);
         if (track) begin
            if (wr) begin
               exp_t e;
               for (int i = 0; i < BW; i++) model[base + i] = wd[i*DW +: DW];
               e.data = '0;
               e.last = 1'b1;
               e.dc   = 1'b0;
               q.push_back(e);
            end else begin
               for (int k = 0; k < BW; k++) begin
                  int   w;
                  int   a;
                  exp_t e;
`ifdef BURST_MEM_CRITICAL_WORD_FIRST_EN
                  w = ((addr % BW) + k) % BW;
`else
                  w = k;
`endif
                  a = base + w;
                  e.last = (k == BW - 1);
                  if (model.exists(a)) begin
                     e.data = model[a];
                     e.dc   = 1'b0;
                  end else begin
                     e.data = '0;
                     e.dc   = 1'b1;
                  end
                  q.push_back(e);
               end
            end
         end
      end
   endtask

   // Wait until all expected beats are consumed, then check the accept-to-
   // first-valid latency.
   task automatic finish_req(input int lat);
      int t;
      t = 0;
      while ((q.size() != 0 || busy) && t < 400) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk(t < 400, "completion_timeout", t, 0);
      chk(rise_cyc - acc_cyc == lat, "latency", rise_cyc - acc_cyc, lat);
   endtask

   task automatic do_reset_cycle();
      rst = 1'b1;
      q.delete();
      busy       = 1'b0;
      beats_done = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // resp_ready driver: scripted stall on a given beat, else random or high.
   initial begin
      bus.resp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_left > 0 && beats_done == stall_beat && bus.resp_valid) begin
            bus.resp_ready = 1'b0;
            stall_left--;
         end else begin
            bus.resp_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
      end
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         chk({bus.req_ready, bus.resp_valid, bus.resp_last} == 3'b000 && bus.resp_data == '0,
             "reset_outputs", {bus.req_ready, bus.resp_valid, bus.resp_last, bus.resp_data}, 0);
         prev_stall = 1'b0;
         prev_valid = 1'b0;
      end else begin
         chk(bus.req_ready == !busy, "req_ready", bus.req_ready, !busy);
         if (prev_stall) begin
            chk(bus.resp_valid && bus.resp_data == prev_data && bus.resp_last == prev_last,
                "stall_hold", {bus.resp_valid, bus.resp_last, bus.resp_data},
                {1'b1, prev_last, prev_data});
         end
         if (bus.resp_valid && !prev_valid) rise_cyc = cyc;
         if (bus.resp_valid) begin
            if (q.size() == 0) begin
               chk(1'b0, "spurious_resp", bus.resp_data, 0);
            end else if (bus.resp_ready) begin
               exp_t e;
               e = q.pop_front();
               chk(e.dc || bus.resp_data == e.data, "resp_data", bus.resp_data, e.data);
               chk(bus.resp_last == e.last, "resp_last", bus.resp_last, e.last);
               beats_done++;
               if (e.last) begin
                  busy         = 1'b0;
                  beats_done   = 0;
                  last_hs_edge = cyc + 1;
               end
            end else begin
               stall_cycles++;
            end
         end
         prev_stall = bus.resp_valid && !bus.resp_ready;
         prev_data  = bus.resp_data;
         prev_last  = bus.resp_last;
         prev_valid = bus.resp_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pool[6];
      int first_acc;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Known content at block 0 so later traffic can prove it is untouched.
      do_req(1'b1, 'h0000, mk('h5A00, 'h5A01, 'h5A02, 'h5A03), 1'b1);
      finish_req(LAT + BW + 1);

      // Block write, acknowledge timing.
      do_req(1'b1, 'h0010, mk('hA0, 'hA1, 'hA2, 'hA3), 1'b1);
      finish_req(LAT + BW + 1);

      // Read of the same block from a non-zero offset.
      do_req(1'b0, 'h0012, '0, 1'b1);
      finish_req(LAT);

      // Stall three cycles on beat 1.
      stall_cycles = 0;
      stall_beat   = 1;
      stall_left   = 3;
      do_req(1'b0, 'h0011, '0, 1'b1);
      finish_req(LAT);
      chk(stall_cycles == 3, "stall_cycles", stall_cycles, 3);

      // Second request held while the first burst is in flight.
      do_req(1'b0, 'h0013, '0, 1'b1);
      first_acc = acc_cyc;
      do_req(1'b0, 'h0001, '0, 1'b1);
      chk(acc_cyc == last_hs_edge + 1, "busy_accept_edge", acc_cyc, last_hs_edge + 1);
      chk(acc_cyc > first_acc + LAT + BW, "busy_not_early", acc_cyc, first_acc + LAT + BW + 1);
      finish_req(LAT);

      // Top block, no wrap to address 0.
      do_req(1'b1, 'hFFFC, mk(1, 2, 3, 4), 1'b1);
      finish_req(LAT + BW + 1);
      do_req(1'b0, 'hFFFC, '0, 1'b1);
      finish_req(LAT);
      do_req(1'b0, 'hFFFF, '0, 1'b1);
      finish_req(LAT);
      do_req(1'b0, 'h0000, '0, 1'b1);
      finish_req(LAT);

      // Reset on the second write edge of a block write.
      do_req(1'b1, 'h0020, mk('hB0, 'hB1, 'hB2, 'hB3), 1'b1);
      finish_req(LAT + BW + 1);
      do_req(1'b1, 'h0020, mk('hC0, 'hC1, 'hC2, 'hC3), 1'b0);
      repeat (LAT + 1) @(posedge clk);
      #1;
      do_reset_cycle();
      model['h0020] = 'hC0;
      model.delete('h0021);
      repeat (12) @(posedge clk);
      #1;
      do_req(1'b0, 'h0020, '0, 1'b1);
      finish_req(LAT);

      // Randomized traffic over a small pool of blocks, random back-pressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pool[i] = $urandom_range(0, (1 << AW) / BW - 1) * BW;
         do_req(1'b1, pool[i], rnd_blk(), 1'b1);
         finish_req(LAT + BW + 1);
      end
      for (int n = 0; n < 40; n++) begin
         int  a;
         bit  wr;
         a  = pool[$urandom_range(0, 5)] + $urandom_range(0, BW - 1);
         wr = ($urandom_range(0, 2) == 0);
         do_req(wr, a, rnd_blk(), 1'b1);
         finish_req(wr ? (LAT + BW + 1) : LAT);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rand_ready = 1'b0;

      // Block 0 still holds its original words after all the traffic above
      // (unless the random pool happened to pick it, which the model tracks).
      do_req(1'b0, 'h0002, '0, 1'b1);
      finish_req(LAT);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/burst_main_memory.md
Name: burst_main_memory

Overview:
- Parametrised successor to the single-word main memory; serves block-sized (cache-line) transfers for the cache controller.
- Valid/ready request and response channels with a programmable access latency modelling DRAM delay.
- Reads return BLOCK_WORDS beats, one word per beat. Writes store a whole block, then return a single acknowledge beat.

Parameters:
- ADDR_WIDTH, 16, word-address width; array depth 2^ADDR_WIDTH words.
- DATA_WIDTH, 16, bits per word.
- BLOCK_WORDS, 4, words per burst; power of two, >=2.
- LATENCY, 4, wait cycles between request accept and first data/write activity; >=1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted on an edge where req_valid && req_ready.
- req_write  in  1  1 = block write, 0 = block read.
- req_addr  in  ADDR_WIDTH  word address; low log2(BLOCK_WORDS) bits give the requested word.
- req_wdata  in  BLOCK_WORDS*DATA_WIDTH  write block; word i in bits [i*DATA_WIDTH +: DATA_WIDTH]. Sampled only at accept.
- resp_valid  out  1  response beat present.
- resp_ready  in  1  consumer accepts the beat.
- resp_data  out  DATA_WIDTH  read word; 0 on the write acknowledge.
- resp_last  out  1  final beat of the burst, or the write acknowledge.

Behaviour:
- States: IDLE, WAIT, RBURST, WRITE, WACK.
- IDLE
  - req_ready=1.
  - On accept: latch base = req_addr with low bits cleared, plus req_write and req_wdata.
  - Load the latency counter with LATENCY, then go to WAIT.
- WAIT
  - Counter decrements once per cycle.
  - When it reaches 0: go to RBURST if a read, WRITE if a write.
  - First resp_valid (read) appears in the cycle after the LATENCY-th edge following accept.
- RBURST
  - Beat k (k=0..BLOCK_WORDS-1) carries mem[base+k].
  - resp_valid stays high. resp_data and resp_last are held stable while resp_ready=0.
  - On resp_valid && resp_ready the next beat is presented in the following cycle, giving 1 beat/cycle at full throughput.
  - resp_last=1 only on beat BLOCK_WORDS-1; its handshake returns the block to IDLE.
- WRITE
  - Writes word i to mem[base+i] on consecutive edges, i=0..BLOCK_WORDS-1, then goes to WACK.
  - resp_valid=0 throughout.
- WACK
  - resp_valid=1, resp_last=1, resp_data=0 until resp_ready, then IDLE.
- Timing of the next request:
  - req_ready rises the cycle after the final handshake; no same-edge overlap of response completion and a new accept.
- Addressing:
  - Bursts never cross a block boundary. base+k is computed within the aligned block; no carry into the upper bits.
  - Top block (all-ones upper address) is valid; no wrap to address 0.
- Ordering:
  - A write's acknowledge is issued only after all words are stored.
  - A read accepted after a WACK handshake returns the new data.
- Request side while busy:
  - req_valid while not in IDLE is ignored; req_ready=0 and no state is latched.
- Reset:
  - Any state -> IDLE on the edge where rst=1.
  - While rst is high: req_ready=0, resp_valid=0, resp_last=0, resp_data=0.
  - req_ready=1 in the first cycle after rst falls.
  - Memory contents are not cleared. Reset mid-WRITE leaves words already written updated and later words unchanged.
  - Reset mid-burst drops the remaining beats with no further resp_valid.
- Memory is single-ported with synchronous read; at most one array access per cycle.

Optional Feature:
- Macro: BURST_MEM_CRITICAL_WORD_FIRST_EN.
- Defined: read beat k returns mem[base + ((off+k) mod BLOCK_WORDS)], where off = req_addr low bits. The requested word comes first and the burst wraps within the block. resp_last is still on the BLOCK_WORDS-th beat. Writes are unaffected and always start at word 0.
- Undefined: off is ignored and read beats always start at word 0.

Test Plan:
- Defaults. Write block 0x0010 with words {0xA0,0xA1,0xA2,0xA3}, resp_ready=1 -> WACK exactly LATENCY+BLOCK_WORDS+1=9 cycles after accept; resp_data=0 and resp_last=1 on that beat.
- Read 0x0012 after that write, resp_ready=1 -> first beat 4 cycles after accept; beats 0xA0,0xA1,0xA2,0xA3 (0xA2,0xA3,0xA0,0xA1 with the macro) on consecutive cycles; resp_last only on the 4th; req_ready=1 the next cycle.
- Read with resp_ready low for 3 cycles on beat 1 -> beat 1 data and resp_last=0 held stable; the stream resumes with no lost or duplicated beats.
- req_valid held high during a read burst with a different address -> not accepted until IDLE. The second request is served after req_ready rises and returns its own block.
- Write 0xFFFC with {1,2,3,4}, then read back -> 1,2,3,4 returned, and address 0x0000 is unchanged.
- Assert rst for 1 cycle during the 2nd write edge of a block write to 0x0020 -> resp_valid=0 from that cycle, req_ready=1 after rst falls. Reading back gives the new word 0 and the old words 2-3.
